// File: rtl/pipeline_ctrl_pkg.sv
// Shared cause codes, FSM state type and default redirect vectors for the
// pipeline controller and its helpers.
package pipeline_ctrl_pkg;

   localparam logic [31:0] CAUSE_NONE = 32'h0000_0000;
   localparam logic [31:0] CAUSE_INT  = 32'h0000_0001;
   localparam logic [31:0] CAUSE_SYS  = 32'h0000_0008;
   localparam logic [31:0] CAUSE_BRK  = 32'h0000_0009;
   localparam logic [31:0] CAUSE_RI   = 32'h0000_000a;
   localparam logic [31:0] CAUSE_OV   = 32'h0000_000c;
   localparam logic [31:0] CAUSE_TR   = 32'h0000_000d;
   localparam logic [31:0] CAUSE_ERET = 32'h0000_000e;

   localparam logic [31:0] DEF_INT_VEC = 32'h0000_0020;
   localparam logic [31:0] DEF_EXC_VEC = 32'h0040_0004;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      SEL_INT,
      SEL_EPC,
      SEL_EXC
   } target_sel_e;

   // Unknown nonzero causes share the general exception vector.
   function automatic target_sel_e cause_sel(input logic [31:0] cause);
      case (cause)
         CAUSE_INT:  cause_sel = SEL_INT;
         CAUSE_ERET: cause_sel = SEL_EPC;
         CAUSE_SYS, CAUSE_BRK, CAUSE_RI, CAUSE_OV, CAUSE_TR:
                     cause_sel = SEL_EXC;
         default:    cause_sel = SEL_EXC;
      endcase
   endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_watchdog.sv
// Counts consecutive stalled cycles (saturating) and raises a sticky flag
// once the count reaches LIMIT.
module stall_watchdog
#(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic stall_active_i,
   output logic timeout_o
);

   localparam int             CW      = $clog2(LIMIT + 1);
   localparam logic [CW-1:0]  LIMIT_C = CW'(LIMIT);

   logic [CW-1:0] cnt_reg, cnt_next;
   logic          flag_reg, flag_next;

   always_comb begin
      cnt_next = '0;
      if (stall_active_i) begin
         cnt_next = (cnt_reg == LIMIT_C) ? cnt_reg : cnt_reg + CW'(1);
      end
      flag_next = flag_reg | (cnt_next == LIMIT_C);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg  <= '0;
         flag_reg <= 1'b0;
      end else begin
         cnt_reg  <= cnt_next;
         flag_reg <= flag_next;
      end
   end

   assign timeout_o = flag_reg;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: per-stage stall generation, exception
// flush with PC redirect, and a consecutive-stall watchdog.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int          STAGES       = 6,
   parameter int          NSRC         = 2,
   parameter int          WIDTH        = 32,
   parameter int          FLUSH_CYCLES = 1,
   parameter logic [31:0] INT_VEC      = DEF_INT_VEC,
   parameter logic [31:0] EXC_VEC      = DEF_EXC_VEC,
   parameter int          WDOG_LIMIT   = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NSRC-1:0]   stallreq_i,
   input  logic [31:0]       excepttype_i,
   input  logic [WIDTH-1:0]  cp0_epc_i,
   output logic [STAGES-1:0] stall_o,
   output logic              flush_o,
   output logic [WIDTH-1:0]  new_pc_o,
   output logic              redirect_o,
   output logic              busy_o,
   output logic              stall_timeout_o
);

   localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

   state_e            state_reg, state_next;
   logic [3:0]        cnt_reg, cnt_next;
   logic [WIDTH-1:0]  pc_reg, pc_next;
   logic [WIDTH-1:0]  target;
   logic [STAGES-1:0] stall_req_mask;
   logic              exc_pending;
   logic              stall_active;

   assign exc_pending = (excepttype_i != CAUSE_NONE);

   always_comb begin
      case (cause_sel(excepttype_i))
         SEL_INT: target = WIDTH'(INT_VEC);
         SEL_EPC: target = cp0_epc_i;
         default: target = WIDTH'(EXC_VEC);
      endcase
   end

   // Stage gi holds when any source k with k+2 >= gi requests a stall, so the
   // highest requesting source decides how deep the hold reaches.
   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stall_bit
         localparam int LO = (gi > 2) ? gi - 2 : 0;
         if (LO < NSRC) begin : g_reach
            assign stall_req_mask[gi] = |stallreq_i[NSRC-1:LO];
         end else begin : g_none
            assign stall_req_mask[gi] = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         pc_reg    <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         pc_reg    <= pc_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      pc_next    = pc_reg;
      case (state_reg)
         IDLE: begin
            pc_next = '0;
            if (exc_pending) begin
               state_next = FLUSH;
               cnt_next   = FLUSH_LOAD;
               pc_next    = target;
            end
         end
         FLUSH: begin
            if (cnt_reg == 4'd0) begin
               state_next = IDLE;
               pc_next    = '0;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // The counter is freshly loaded in the first flush cycle, which marks
   // the single redirect pulse.
   always_comb begin
      flush_o    = 1'b0;
      busy_o     = 1'b0;
      redirect_o = 1'b0;
      stall_o    = '0;
      if (state_reg == FLUSH) begin
         flush_o    = 1'b1;
         busy_o     = 1'b1;
         redirect_o = (cnt_reg == FLUSH_LOAD);
      end else if (rst && !exc_pending) begin
         stall_o = stall_req_mask;
      end
   end

   assign new_pc_o     = pc_reg;
   assign stall_active = |stall_o;

   stall_watchdog #(
      .LIMIT (WDOG_LIMIT)
   ) u_wdog (
      .clk            (clk),
      .rst            (rst),
      .stall_active_i (stall_active),
      .timeout_o      (stall_timeout_o)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomized plus directed bench for pipeline_ctrl: two instances with
// different flush lengths and watchdog limits share one stimulus stream.
module tb_pipeline_ctrl;

   localparam int STAGES = 6;
   localparam int NSRC   = 2;
   localparam int WIDTH  = 32;
   localparam int FC_A   = 1;
   localparam int WD_A   = 4;
   localparam int FC_B   = 3;
   localparam int WD_B   = 6;

   typedef struct packed {
      logic        fl;
      logic [7:0]  rem;
      logic        first;
      logic [31:0] pc;
      logic [15:0] wd;
      logic        to;
   } mdl_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NSRC-1:0]   stallreq_i = '0;
   logic [31:0]       excepttype_i = '0;
   logic [WIDTH-1:0]  cp0_epc_i = '0;

   logic [STAGES-1:0] stall_a, stall_b;
   logic              flush_a, flush_b, redir_a, redir_b, busy_a, busy_b, to_a, to_b;
   logic [WIDTH-1:0]  pc_a, pc_b;

   int   n_cmp = 0;
   int   n_err = 0;
   mdl_t ma, mb;

   always #5 clk = ~clk;

   pipeline_ctrl #(
      .STAGES(STAGES), .NSRC(NSRC), .WIDTH(WIDTH),
      .FLUSH_CYCLES(FC_A), .WDOG_LIMIT(WD_A)
   ) u_dut_a (
      .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
      .cp0_epc_i(cp0_epc_i), .stall_o(stall_a), .flush_o(flush_a), .new_pc_o(pc_a),
      .redirect_o(redir_a), .busy_o(busy_a), .stall_timeout_o(to_a)
   );

   pipeline_ctrl #(
      .STAGES(STAGES), .NSRC(NSRC), .WIDTH(WIDTH),
      .FLUSH_CYCLES(FC_B), .WDOG_LIMIT(WD_B)
   ) u_dut_b (
      .clk(clk), .rst(rst), .stallreq_i(stallreq_i), .excepttype_i(excepttype_i),
      .cp0_epc_i(cp0_epc_i), .stall_o(stall_b), .flush_o(flush_b), .new_pc_o(pc_b),
      .redirect_o(redir_b), .busy_o(busy_b), .stall_timeout_o(to_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Number of held stages = min(k+3, STAGES) for the highest requesting source k.
   function automatic logic [STAGES-1:0] exp_stall(input logic [NSRC-1:0] req,
         input logic [31:0] exc, input logic in_flush, input logic rst_v);
      int n;
      n = 0;
      for (int k = 0; k < NSRC; k++) begin
         if (req[k]) n = (k + 3 > STAGES) ? STAGES : k + 3;
      end
      if (in_flush || exc != 0 || !rst_v) n = 0;
      return STAGES'((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [31:0] exp_target(input logic [31:0] exc, input logic [31:0] epc);
      if (exc == 32'h01) return 32'h0000_0020;
      if (exc == 32'h0e) return epc;
      return 32'h0040_0004;
   endfunction

   function automatic mdl_t step(input mdl_t m, input int fc, input int lim,
         input logic [NSRC-1:0] req, input logic [31:0] exc, input logic [31:0] epc);
      mdl_t r;
      r = m;
      if (exp_stall(req, exc, m.fl, 1'b1) != 0)
         r.wd = (int'(m.wd) + 1 > lim) ? 16'(lim) : m.wd + 16'd1;
      else
         r.wd = '0;
      if (int'(r.wd) >= lim) r.to = 1'b1;
      if (m.fl) begin
         r.rem   = m.rem - 8'd1;
         r.first = 1'b0;
         if (r.rem == 0) begin
            r.fl = 1'b0;
            r.pc = '0;
         end
      end else if (exc != 0) begin
         r.fl    = 1'b1;
         r.rem   = 8'(fc);
         r.first = 1'b1;
         r.pc    = exp_target(exc, epc);
      end
      return r;
   endfunction

   task automatic cmp_dut(input string p, input mdl_t m, input logic [STAGES-1:0] st,
         input logic fl, input logic rd, input logic bz, input logic [31:0] pc, input logic to);
      chk({p, ".stall"},    64'(st), 64'(exp_stall(stallreq_i, excepttype_i, m.fl, rst)));
      chk({p, ".flush"},    64'(fl), 64'(m.fl));
      chk({p, ".redirect"}, 64'(rd), 64'(m.fl & m.first));
      chk({p, ".busy"},     64'(bz), 64'(m.fl));
      chk({p, ".new_pc"},   64'(pc), 64'(m.pc));
      chk({p, ".timeout"},  64'(to), 64'(m.to));
   endtask

   task automatic check_both();
      cmp_dut("a", ma, stall_a, flush_a, redir_a, busy_a, pc_a, to_a);
      cmp_dut("b", mb, stall_b, flush_b, redir_b, busy_b, pc_b, to_b);
   endtask

   task automatic apply(input logic [NSRC-1:0] req, input logic [31:0] exc, input logic [31:0] epc);
      stallreq_i   = req;
      excepttype_i = exc;
      cp0_epc_i    = epc;
      @(negedge clk);
      check_both();
   endtask

   task automatic tick();
      @(posedge clk);
      ma = step(ma, FC_A, WD_A, stallreq_i, excepttype_i, cp0_epc_i);
      mb = step(mb, FC_B, WD_B, stallreq_i, excepttype_i, cp0_epc_i);
      #1;
   endtask

   task automatic cycle(input logic [NSRC-1:0] req, input logic [31:0] exc, input logic [31:0] epc);
      apply(req, exc, epc);
      tick();
   endtask

   // Asserted mid-cycle so the asynchronous path is what clears the outputs.
   task automatic do_reset();
      stallreq_i   = 2'b11;
      excepttype_i = 32'h0;
      rst          = 1'b0;
      #1;
      ma = '0;
      mb = '0;
      check_both();
      repeat (2) @(posedge clk);
      #2;
      check_both();
      rst = 1'b1;
   endtask

   function automatic logic [31:0] rand_cause();
      logic [31:0] codes [5];
      codes[0] = 32'h08; codes[1] = 32'h09; codes[2] = 32'h0a;
      codes[3] = 32'h0c; codes[4] = 32'h0d;
      case ($urandom_range(0, 9))
         5:       return 32'h01;
         6:       return 32'h0e;
         7:       return codes[$urandom_range(0, 4)];
         8:       return $urandom | 32'h100;
         9:       return 32'h08;
         default: return 32'h0;
      endcase
   endfunction

   initial begin
      ma = '0;
      mb = '0;
      @(posedge clk);
      #1;
      do_reset();
      chk("reset.stall_a", 64'(stall_a), 64'h0);

      apply(2'b01, 32'h0, 32'h0); chk("stall01", 64'(stall_a), 64'h07); tick();
      apply(2'b11, 32'h0, 32'h0); chk("stall11", 64'(stall_a), 64'h0f); tick();
      apply(2'b00, 32'h0, 32'h0); chk("stall00", 64'(stall_a), 64'h00); tick();

      cycle(2'b00, 32'h08, 32'h0);
      apply(2'b00, 32'h0, 32'h0);
      chk("sys.flush", 64'(flush_a), 64'h1);
      chk("sys.redirect", 64'(redir_a), 64'h1);
      chk("sys.new_pc", 64'(pc_a), 64'h0040_0004);
      tick();
      apply(2'b00, 32'h0, 32'h0);
      chk("sys.flush_end", 64'(flush_a), 64'h0);
      chk("sys.pc_end", 64'(pc_a), 64'h0);
      tick();
      repeat (3) cycle(2'b00, 32'h0, 32'h0);

      apply(2'b11, 32'h0e, 32'h0040_0120); chk("eret.stall", 64'(stall_a), 64'h0); tick();
      apply(2'b00, 32'h0, 32'h0); chk("eret.new_pc", 64'(pc_a), 64'h0040_0120); tick();
      repeat (3) cycle(2'b00, 32'h0, 32'h0);

      cycle(2'b00, 32'h01, 32'h0);
      for (int i = 0; i < 3; i++) begin
         apply(2'b00, (i == 1) ? 32'h08 : 32'h0, 32'h0);
         chk("int.flush_b", 64'(flush_b), 64'h1);
         chk("int.new_pc_b", 64'(pc_b), 64'h20);
         chk("int.redirect_b", 64'(redir_b), (i == 0) ? 64'h1 : 64'h0);
         tick();
      end
      apply(2'b00, 32'h0, 32'h0); chk("int.flush_b_end", 64'(flush_b), 64'h0); tick();
      repeat (3) cycle(2'b00, 32'h0, 32'h0);

      repeat (3) cycle(2'b01, 32'h0, 32'h0);
      cycle(2'b00, 32'h0, 32'h0);
      repeat (3) cycle(2'b01, 32'h0, 32'h0);
      apply(2'b01, 32'h0, 32'h0); chk("wdog.before", 64'(to_a), 64'h0); tick();
      apply(2'b00, 32'h0, 32'h0); chk("wdog.set", 64'(to_a), 64'h1); tick();
      apply(2'b00, 32'h0, 32'h0); chk("wdog.sticky", 64'(to_a), 64'h1); tick();

      cycle(2'b00, 32'h01, 32'h0);
      cycle(2'b00, 32'h0, 32'h0);
      do_reset();
      chk("rst.flush_b", 64'(flush_b), 64'h0);
      chk("rst.timeout_a", 64'(to_a), 64'h0);
      for (int i = 0; i < 3; i++) begin
         apply(2'b00, 32'h0, 32'h0);
         chk("rst.no_redirect_b", 64'(redir_b), 64'h0);
         tick();
      end

      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 63) == 0) do_reset();
         cycle(NSRC'($urandom), rand_cause(), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL sim_time_limit: got expired expected finish");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter STAGES, default 6: number of pipeline stages; width of stall_o (bit 0 = PC hold, bit k = stage k hold).
REQ-002 Parameter NSRC, default 2: number of stall-request sources; source k stalls bits [k+2:0].
REQ-003 Parameter WIDTH, default 32: address width of cp0_epc_i and new_pc_o.
REQ-004 Parameter FLUSH_CYCLES, default 1: cycles flush_o stays high per exception, range 1..15.
REQ-005 Parameter INT_VEC, default 32'h00000020: interrupt handler address.
REQ-006 Parameter EXC_VEC, default 32'h00400004: handler address for all non-interrupt, non-eret causes.
REQ-007 Parameter WDOG_LIMIT, default 1024: consecutive-stall cycles before timeout, range 2..65535.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 rst  in  1  asynchronous, active-low reset.
REQ-010 stallreq_i  in  NSRC  per-source stall request; index 0 = decode, index 1 = execute.
REQ-011 excepttype_i  in  32  exception cause from MEM; 0 = none.
REQ-012 cp0_epc_i  in  WIDTH  EPC for eret.
REQ-013 stall_o  out  STAGES  per-stage hold.
REQ-014 flush_o  out  1  pipeline flush.
REQ-015 new_pc_o  out  WIDTH  redirect target, valid while flush_o=1.
REQ-016 redirect_o  out  1  one-cycle pulse, first flush cycle only.
REQ-017 busy_o  out  1  high while state is FLUSH.
REQ-018 stall_timeout_o  out  1  sticky stall-watchdog flag.

Function
REQ-019 FSM states are IDLE and FLUSH.
REQ-020 IDLE, excepttype_i != 0: go to FLUSH next edge; capture target into new_pc_o; load flush counter with FLUSH_CYCLES-1.
REQ-021 Target decode: 0x01 -> INT_VEC; 0x0e -> cp0_epc_i; 0x08, 0x09, 0x0a, 0x0c, 0x0d and any other nonzero code -> EXC_VEC.
REQ-022 FLUSH: flush_o=1 and busy_o=1; redirect_o=1 only in the first FLUSH cycle; counter decrements each cycle; at 0 return to IDLE.
REQ-023 excepttype_i is ignored in FLUSH; new_pc_o holds its captured value throughout FLUSH.
REQ-024 Latency: exception seen at edge N gives flush_o/redirect_o high in cycle N+1.
REQ-025 stall_o is combinational in IDLE: highest-index asserted source k gives bits [k+2:0] set (capped at STAGES-1); no request gives 0.
REQ-026 stall_o=0 in FLUSH, and in any IDLE cycle with excepttype_i != 0; exceptions override stalls.
REQ-027 Watchdog counts consecutive cycles with stall_o != 0; clears on any cycle with stall_o = 0; saturates.
REQ-028 Watchdog count reaching WDOG_LIMIT sets stall_timeout_o; the flag stays set until reset.
REQ-029 In IDLE, flush_o, redirect_o and busy_o are 0; new_pc_o returns to 0 on the first IDLE cycle.

Reset
REQ-030 rst low asynchronously forces: state IDLE; stall_o, flush_o, redirect_o, busy_o, stall_timeout_o, new_pc_o, flush counter and watchdog counter all 0.
REQ-031 Reset mid-FLUSH aborts the flush immediately; no redirect is issued after rst deasserts.
REQ-032 While rst is low, stall_o is 0 regardless of stallreq_i.

Structure
REQ-033 Package pipeline_ctrl_pkg holds: cause codes (INT 0x01, SYS 0x08, BRK 0x09, RI 0x0a, OV 0x0c, TR 0x0d, ERET 0x0e), the state enum, and default vector constants.
REQ-034 Sub-module stall_watchdog (counter, saturation, sticky flag) is instantiated once.

Verification
REQ-035 stallreq_i=2'b01 -> stall_o=6'b000111; 2'b11 -> 6'b001111; 2'b00 -> 0, same cycle.
REQ-036 excepttype_i=0x08 for 1 cycle, FLUSH_CYCLES=1 -> next cycle flush_o=1, redirect_o=1, new_pc_o=0x00400004; following cycle all 0.
REQ-037 cp0_epc_i=0x00400120, excepttype_i=0x0e with stallreq_i=2'b11 in the same cycle -> stall_o=0 that cycle; next cycle new_pc_o=0x00400120.
REQ-038 FLUSH_CYCLES=3, excepttype_i=0x01 -> flush_o high 3 cycles with new_pc_o=0x20; redirect_o high only in cycle 1; a second exception during FLUSH is ignored.
REQ-039 WDOG_LIMIT=4, stallreq_i=2'b01 held 3 cycles, dropped 1, then held 4 -> stall_timeout_o rises after the 4th consecutive cycle and stays set.
REQ-040 rst low during FLUSH cycle 2 of 3 -> all outputs 0 immediately; after rst release, no redirect_o pulse.
